// File: rtl/lzrw1_pkg.sv
// Shared constants and types for the LZRW1 output packer.
package lzrw1_pkg;

  localparam int GROUP_ITEMS = 16;
  localparam int BUF_BYTES   = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CW_LO = 2'd1,
    CW_HI = 2'd2,
    DATA  = 2'd3
  } pack_state_t;

  typedef struct packed {
    logic        copy;
    logic [3:0]  length;
    logic [11:0] offset;
    logic [7:0]  literal;
  } lzrw1_item_t;

endpackage

// File: rtl/lzrw1_group_buf.sv
// 32x8 group buffer: one- or two-byte write at wr_addr, combinational read, synchronous clear.
module lzrw1_group_buf
  import lzrw1_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       wr_en,
  input  logic       wr_two,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data0,
  input  logic [7:0] wr_data1,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [BUF_BYTES];
  logic [4:0] wr_addr1;

  // A two-byte copy never starts at the last slot, so this never wraps in use.
  assign wr_addr1 = wr_addr + 5'd1;
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < BUF_BYTES; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data0;
      if (wr_two) mem[wr_addr1] <= wr_data1;
    end
  end

endmodule

// File: rtl/lzrw1_group_packer.sv
// LZRW1 group packer: buffers up to 16 items, emits control word (low byte first) then item bytes.
// Optional item/byte statistics counters are built when LZRW1_PACK_STATS_EN is defined.
module lzrw1_group_packer
  import lzrw1_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_copy,
  input  logic [3:0]  in_length,
  input  logic [11:0] in_offset,
  input  logic [7:0]  in_literal,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
`ifdef LZRW1_PACK_STATS_EN
  ,
  output logic [31:0] stat_items,
  output logic [31:0] stat_bytes
`endif
);

  pack_state_t state, next_state;
  lzrw1_item_t item;
  logic [4:0]  item_cnt;
  logic [5:0]  wr_ptr, rd_ptr;
  logic [15:0] ctrl_word;
  logic        last_grp;
  logic        accept, close, grp_done, at_end;
  logic [7:0]  rd_data, wr_data0;

  assign item     = {in_copy, in_length, in_offset, in_literal};
  assign at_end   = (rd_ptr == wr_ptr - 6'd1);
  assign busy     = (state != FILL) || (item_cnt != 5'd0);
  assign wr_data0 = item.copy ? {item.length, item.offset[11:8]} : item.literal;

  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    accept     = 1'b0;
    close      = 1'b0;
    grp_done   = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && ((item_cnt == 5'(GROUP_ITEMS - 1)) || in_last)) begin
          close      = 1'b1;
          next_state = CW_LO;
        end
      end
      CW_LO: begin
        out_valid = 1'b1;
        out_data  = ctrl_word[7:0];
        if (out_ready) next_state = CW_HI;
      end
      CW_HI: begin
        out_valid = 1'b1;
        out_data  = ctrl_word[15:8];
        if (out_ready) next_state = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = rd_data;
        out_last  = last_grp && at_end;
        if (out_ready && at_end) begin
          grp_done   = 1'b1;
          next_state = FILL;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // Group bookkeeping; a finished emit wipes everything so the next group starts clean.
  always_ff @(posedge clock) begin
    if (reset || grp_done) begin
      item_cnt  <= 5'd0;
      wr_ptr    <= 6'd0;
      rd_ptr    <= 6'd0;
      ctrl_word <= 16'h0000;
      last_grp  <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_word[item_cnt[3:0]] <= item.copy;
        item_cnt <= item_cnt + 5'd1;
        wr_ptr   <= wr_ptr + (item.copy ? 6'd2 : 6'd1);
      end
      if (close) last_grp <= in_last;
      if (state == DATA && out_ready) rd_ptr <= rd_ptr + 6'd1;
    end
  end

  lzrw1_group_buf u_buf (
    .clock    (clock),
    .clear    (reset || grp_done),
    .wr_en    (accept),
    .wr_two   (item.copy),
    .wr_addr  (wr_ptr[4:0]),
    .wr_data0 (wr_data0),
    .wr_data1 (item.offset[7:0]),
    .rd_addr  (rd_ptr[4:0]),
    .rd_data  (rd_data)
  );

`ifdef LZRW1_PACK_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_items <= 32'd0;
      stat_bytes <= 32'd0;
    end else begin
      if (accept) stat_items <= stat_items + 32'd1;
      if (out_valid && out_ready) stat_bytes <= stat_bytes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Directed table-driven bench for lzrw1_group_packer (optionally with LZRW1_PACK_STATS_EN).
module tb_lzrw1_group_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_copy, in_last;
  logic [3:0]  in_length;
  logic [11:0] in_offset;
  logic [7:0]  in_literal;
  logic        out_valid, out_ready, out_last, busy;
  logic [7:0]  out_data;
`ifdef LZRW1_PACK_STATS_EN
  logic [31:0] stat_items, stat_bytes;
`endif

  always #5 clock = ~clock;

  lzrw1_group_packer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_copy    (in_copy),
    .in_length  (in_length),
    .in_offset  (in_offset),
    .in_literal (in_literal),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef LZRW1_PACK_STATS_EN
    ,
    .stat_items (stat_items),
    .stat_bytes (stat_bytes)
`endif
  );

  typedef struct {
    logic        copy;
    logic [3:0]  len;
    logic [11:0] off;
    logic [7:0]  lit;
    logic        last;
    int          nexp;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  typedef struct {
    int          first;
    int          count;
    logic [15:0] ctrl;
    bit          toggle;
    bit          last;
  } grp_t;

  vec_t       vecs[35];
  grp_t       grps[4];
  logic [7:0] exp_data[40];
  bit         exp_last[40];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic copy, input logic [3:0] len, input logic [11:0] off,
                              input logic [7:0] lit, input logic last, input int nexp,
                              input logic [7:0] e0, input logic [7:0] e1);
    vec_t v;
    v.copy = copy; v.len = len; v.off = off; v.lit = lit; v.last = last;
    v.nexp = nexp; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic push(input vec_t v);
    int w;
    w = 0;
    in_valid = 1'b1; in_copy = v.copy; in_length = v.len;
    in_offset = v.off; in_literal = v.lit; in_last = v.last;
    @(negedge clock);
    while (!in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Collects n bytes against exp_data/exp_last; returns at the negedge of the last sampled byte.
  task automatic collect(input int n, input bit toggle, input int gid, output int cycles);
    int k;
    logic [7:0] held;
    bit stalled, rdy_bad;
    k = 0; cycles = 0; stalled = 0; rdy_bad = 0; held = 8'h00;
    out_ready = 1'b1;
    while (k < n && cycles < 300) begin
      @(negedge clock);
      cycles++;
      if (toggle) out_ready = ~out_ready;
      if (stalled)
        chk($sformatf("g%0d_hold%0d", gid, k), {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
      if (out_valid && in_ready) rdy_bad = 1;
      if (out_valid && out_ready) begin
        chk($sformatf("g%0d_data%0d", gid, k), {24'd0, out_data}, {24'd0, exp_data[k]});
        chk($sformatf("g%0d_last%0d", gid, k), {31'd0, out_last}, {31'd0, exp_last[k]});
        k++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held    = out_data;
      end
    end
    chk($sformatf("g%0d_count", gid), k, n);
    chk($sformatf("g%0d_in_ready_low", gid), {31'd0, rdy_bad}, 32'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clock);
    chk({name, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  initial begin
    int n, cyc;
    for (int i = 0; i < 16; i++) vecs[i] = mk(1'b0, 4'h0, 12'h000, 8'(i), 1'b0, 1, 8'(i), 8'h00);
    for (int i = 16; i < 32; i++) vecs[i] = mk(1'b1, 4'h3, 12'hABC, 8'h00, 1'b0, 2, 8'h3A, 8'hBC);
    vecs[32] = mk(1'b0, 4'h0, 12'h000, 8'h41, 1'b0, 1, 8'h41, 8'h00);
    vecs[33] = mk(1'b1, 4'h2, 12'h005, 8'h00, 1'b1, 2, 8'h20, 8'h05);
    vecs[34] = mk(1'b0, 4'h0, 12'h000, 8'h7E, 1'b1, 1, 8'h7E, 8'h00);
    grps[0] = '{first: 0,  count: 16, ctrl: 16'h0000, toggle: 1'b0, last: 1'b0};
    grps[1] = '{first: 16, count: 16, ctrl: 16'hFFFF, toggle: 1'b0, last: 1'b0};
    grps[2] = '{first: 32, count: 2,  ctrl: 16'h0002, toggle: 1'b0, last: 1'b1};
    grps[3] = '{first: 0,  count: 16, ctrl: 16'h0000, toggle: 1'b1, last: 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_copy = 1'b0; in_last = 1'b0;
    in_length = 4'h0; in_offset = 12'h000; in_literal = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clock); #1;

    for (int g = 0; g < 4; g++) begin
      pulse_reset();
      n = 2;
      exp_data[0] = grps[g].ctrl[7:0];
      exp_data[1] = grps[g].ctrl[15:8];
      for (int r = grps[g].first; r < grps[g].first + grps[g].count; r++) begin
        push(vecs[r]);
        if (r == grps[g].first) chk($sformatf("g%0d_busy_fill", g), {31'd0, busy}, 32'd1);
        exp_data[n] = vecs[r].e0; n++;
        if (vecs[r].nexp == 2) begin exp_data[n] = vecs[r].e1; n++; end
      end
      for (int i = 0; i < n; i++) exp_last[i] = grps[g].last && (i == n - 1);
      collect(n, grps[g].toggle, g, cyc);
      if (!grps[g].toggle) chk($sformatf("g%0d_cycles", g), cyc, n);
      @(posedge clock); #1;
      check_idle($sformatf("g%0d_after", g));
`ifdef LZRW1_PACK_STATS_EN
      chk($sformatf("g%0d_stat_items", g), stat_items, grps[g].count);
      chk($sformatf("g%0d_stat_bytes", g), stat_bytes, n);
`endif
      @(posedge clock); #1;
    end

    // Reset in the middle of an emit, then a one-literal final group.
    pulse_reset();
    for (int r = 0; r < 16; r++) push(vecs[r]);
    exp_data[0] = 8'h00; exp_data[1] = 8'h00; exp_data[2] = 8'h00;
    for (int i = 0; i < 3; i++) exp_last[i] = 1'b0;
    collect(3, 1'b0, 10, cyc);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_idle("midreset");
    @(posedge clock); #1;
    push(vecs[34]);
    exp_data[0] = 8'h00; exp_data[1] = 8'h00; exp_data[2] = 8'h7E;
    exp_last[0] = 1'b0;  exp_last[1] = 1'b0;  exp_last[2] = 1'b1;
    collect(3, 1'b0, 11, cyc);
    chk("g11_cycles", cyc, 3);
    @(posedge clock); #1;
    check_idle("g11_after");
`ifdef LZRW1_PACK_STATS_EN
    chk("g11_stat_items", stat_items, 32'd1);
    chk("g11_stat_bytes", stat_bytes, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
